fifo_access_ctrl: RTL and testbench

Host-side access controller for the CL↔user-logic FIFO pair. It sits between the decoded register-bus write/read strobes and the two FIFO instances. It serializes host accesses into clean FIFO push/pop pulses, gives every access a response code, waits a bounded time for data on empty-FIFO reads, and exposes a status/drop-count register. Write and read paths are independent and may be serviced in the same cycle.

---
 rtl/fifo_access_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fifo_access_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_ctrl.sv
// Host access controller for the CL<->user-logic FIFO pair: registered write path,
// four-state read FSM with bounded empty-FIFO polling, and a status/drop-count register.
module fifo_access_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] FIFO_ADDR   = 32'h0000_0520,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0524,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_n_sync,
  input  logic              wr_req,
  input  logic [31:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [1:0]        wr_resp,
  input  logic              rd_req,
  input  logic [31:0]       rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_resp,
  output logic              tx_wr,
  output logic [DATA_W-1:0] tx_din,
  input  logic              tx_full,
  output logic              rx_rd,
  input  logic [DATA_W-1:0] rx_dout,
  input  logic              rx_empty
);

  typedef enum logic [1:0] {StIdle, StPoll, StWait, StResp} state_e;

  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [1:0]  RespDecerr = 2'b11;
  localparam logic [15:0] ToLast     = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  LatLast    = 3'(RD_LAT);

  // ---------------- write path ----------------
  logic              w_wr_fifo, w_wr_stat, w_wr_push, w_wr_drop;
  logic [1:0]        w_wr_resp;
  logic              r_tx_wr, r_wr_ack;
  logic [1:0]        r_wr_resp;
  logic [DATA_W-1:0] r_tx_din;
  logic [15:0]       r_drop_cnt;

  assign w_wr_fifo = wr_req && (wr_addr == FIFO_ADDR);
  assign w_wr_stat = wr_req && (wr_addr == STATUS_ADDR);
  assign w_wr_push = w_wr_fifo && !tx_full;
  assign w_wr_drop = w_wr_fifo && tx_full;

  always_comb begin
    w_wr_resp = RespDecerr;
    if (w_wr_drop) begin
      w_wr_resp = RespSlverr;
    end else if (w_wr_fifo || w_wr_stat) begin
      w_wr_resp = RespOkay;
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      r_tx_wr    <= 1'b0;
      r_tx_din   <= '0;
      r_wr_ack   <= 1'b0;
      r_wr_resp  <= RespOkay;
      r_drop_cnt <= '0;
    end else begin
      r_tx_wr   <= w_wr_push;
      r_wr_ack  <= wr_req;
      r_wr_resp <= wr_req ? w_wr_resp : RespOkay;
      if (w_wr_push) begin
        r_tx_din <= wr_data;
      end
      // A status write clears the counter even if a drop is reported in the same cycle.
      if (w_wr_stat) begin
        r_drop_cnt <= '0;
      end else if (w_wr_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign tx_wr   = r_tx_wr;
  assign tx_din  = r_tx_din;
  assign wr_ack  = r_wr_ack;
  assign wr_resp = r_wr_resp;

  // ---------------- read path ----------------
  state_e            r_state, w_state_nxt;
  logic [2:0]        r_lat_cnt, w_lat_nxt;
  logic [15:0]       r_to_cnt, w_to_nxt;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;
  logic [1:0]        r_rd_resp, w_rd_resp_nxt;
  logic              r_rx_rd, w_rx_rd_nxt;
  logic [DATA_W-1:0] w_status, w_dead;

  always_comb begin
    w_status        = '0;
    w_status[31:0]  = {r_drop_cnt, 14'b0, rx_empty, tx_full};
    w_dead          = '0;
    w_dead[31:0]    = 32'hDEAD_0000;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat_cnt;
    w_to_nxt      = r_to_cnt;
    w_rd_data_nxt = r_rd_data;
    w_rd_resp_nxt = r_rd_resp;
    w_rx_rd_nxt   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (rd_req) begin
          if (rd_addr == FIFO_ADDR) begin
            if (!rx_empty) begin
              w_rx_rd_nxt = 1'b1;
              w_lat_nxt   = '0;
              w_state_nxt = StWait;
            end else begin
              w_to_nxt    = '0;
              w_state_nxt = StPoll;
            end
          end else if (rd_addr == STATUS_ADDR) begin
            w_rd_data_nxt = w_status;
            w_rd_resp_nxt = RespOkay;
            w_state_nxt   = StResp;
          end else begin
            w_rd_data_nxt = '0;
            w_rd_resp_nxt = RespDecerr;
            w_state_nxt   = StResp;
          end
        end
      end
      StPoll: begin
        // Data arriving on the last poll cycle still beats the timeout.
        if (!rx_empty) begin
          w_rx_rd_nxt = 1'b1;
          w_lat_nxt   = '0;
          w_state_nxt = StWait;
        end else if (r_to_cnt == ToLast) begin
          w_rd_data_nxt = w_dead;
          w_rd_resp_nxt = RespSlverr;
          w_state_nxt   = StResp;
        end else begin
          w_to_nxt = r_to_cnt + 16'd1;
        end
      end
      StWait: begin
        if (r_lat_cnt == LatLast) begin
          w_rd_data_nxt = rx_dout;
          w_rd_resp_nxt = RespOkay;
          w_state_nxt   = StResp;
        end else begin
          w_lat_nxt = r_lat_cnt + 3'd1;
        end
      end
      StResp: begin
        if (rd_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      r_state   <= StIdle;
      r_lat_cnt <= '0;
      r_to_cnt  <= '0;
      r_rd_data <= '0;
      r_rd_resp <= RespOkay;
      r_rx_rd   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_to_cnt  <= w_to_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_rd_resp <= w_rd_resp_nxt;
      r_rx_rd   <= w_rx_rd_nxt;
    end
  end

  assign rd_valid = (r_state == StResp);
  assign rd_data  = r_rd_data;
  assign rd_resp  = r_rd_resp;
  assign rx_rd    = r_rx_rd;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Self-checking bench for fifo_access_ctrl: write vector table, directed read sequences,
// and randomized writes/reads scored against a cycle-count model of the access rules.
module tb_fifo_access_ctrl;
  localparam int unsigned DW = 32;
  localparam logic [31:0] FA = 32'h0000_0520;
  localparam logic [31:0] SA = 32'h0000_0524;
  localparam int unsigned RL = 1;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0;
  logic [31:0]   wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic [1:0]    wr_resp;
  logic          rd_req = 1'b0;
  logic [31:0]   rd_addr = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;
  logic          tx_wr;
  logic [DW-1:0] tx_din;
  logic          tx_full = 1'b0;
  logic          rx_rd;
  logic [DW-1:0] rx_dout = '0;
  logic          rx_empty = 1'b1;

  always #5 clk = ~clk;

  fifo_access_ctrl #(
    .DATA_W(DW), .FIFO_ADDR(FA), .STATUS_ADDR(SA), .RD_LAT(RL), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_main_a0(clk), .rst_main_n_sync(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_resp(wr_resp),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_resp(rd_resp),
    .tx_wr(tx_wr), .tx_din(tx_din), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_dout(rx_dout), .rx_empty(rx_empty)
  );

  // Behavioural FIFO ends: rx pops one word per rx_rd, tx pushes are logged.
  int            cyc = 0;
  int            n_pops = 0;
  int            last_pop_cyc = -1;
  logic [31:0]   rx_q[$];
  logic [31:0]   tx_log[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_wr) tx_log.push_back(tx_din);
    if (rx_rd) begin
      n_pops       <= n_pops + 1;
      last_pop_cyc <= cyc;
      if (rx_q.size() > 0) rx_dout <= rx_q.pop_front();
      else rx_dout <= 32'hBAD0_BAD0;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the drop counter, updated from the write rules alone.
  logic [15:0] exp_drop = '0;

  task automatic model_write(input logic [31:0] addr, input logic full,
                             output logic e_wr, output logic [1:0] e_resp);
    e_wr = 1'b0;
    if (addr == SA) begin
      exp_drop = '0;
      e_resp   = 2'b00;
    end else if (addr == FA && !full) begin
      e_wr   = 1'b1;
      e_resp = 2'b00;
    end else if (addr == FA) begin
      if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      e_resp = 2'b10;
    end else begin
      e_resp = 2'b11;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int rel, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output int req_cyc);
    rd_addr = addr;
    rd_req  = 1'b1;
    req_cyc = cyc;
    lat     = 0;
    tick();
    lat++;
    rd_req = 1'b0;
    while (!rd_valid && lat < 200) begin
      if (lat == rel) rx_empty = 1'b0;
      tick();
      lat++;
    end
    chk("rd_valid_seen", rd_valid, 1);
    data = rd_data;
    resp = rd_resp;
  endtask

  task automatic accept();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        full;
    logic        exp_wr;
    logic [1:0]  exp_resp;
  } wvec_t;

  wvec_t wv[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        e_wr;
    logic [1:0]  e_resp;
    int          lat, rc, p0;

    wv[0]  = '{FA, 32'd11, 1'b0, 1'b1, 2'b00};
    wv[1]  = '{FA, 32'd22, 1'b0, 1'b1, 2'b00};
    wv[2]  = '{FA, 32'd33, 1'b0, 1'b1, 2'b00};
    wv[3]  = '{SA, 32'd0,  1'b0, 1'b0, 2'b00};
    wv[4]  = '{FA, 32'd101, 1'b1, 1'b0, 2'b10};
    wv[5]  = '{FA, 32'd102, 1'b1, 1'b0, 2'b10};
    wv[6]  = '{FA, 32'd103, 1'b1, 1'b0, 2'b10};
    wv[7]  = '{FA, 32'd104, 1'b1, 1'b0, 2'b10};
    wv[8]  = '{FA, 32'd105, 1'b1, 1'b0, 2'b10};
    wv[9]  = '{32'h0000_0600, 32'hAA, 1'b0, 1'b0, 2'b11};
    wv[10] = '{32'h0000_0521, 32'hBB, 1'b1, 1'b0, 2'b11};
    wv[11] = '{32'h0000_0000, 32'hCC, 1'b0, 1'b0, 2'b11};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_wr", tx_wr, 0);
    chk("rst_tx_din", tx_din, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_wr_resp", wr_resp, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_resp", rd_resp, 0);
    chk("rst_rx_rd", rx_rd, 0);
    rst_n = 1'b1;
    tick();

    // Write vector table, back-to-back
    for (int i = 0; i < 12; i++) begin
      wr_req  = 1'b1;
      wr_addr = wv[i].addr;
      wr_data = wv[i].data;
      tx_full = wv[i].full;
      model_write(wv[i].addr, wv[i].full, e_wr, e_resp);
      tick();
      chk($sformatf("wv%0d_tx_wr", i), tx_wr, wv[i].exp_wr);
      chk($sformatf("wv%0d_wr_ack", i), wr_ack, 1);
      chk($sformatf("wv%0d_wr_resp", i), wr_resp, wv[i].exp_resp);
      if (wv[i].exp_wr) chk($sformatf("wv%0d_tx_din", i), tx_din, wv[i].data);
    end
    wr_req = 1'b0;
    tick();
    chk("wr_ack_one_cycle", wr_ack, 0);
    chk("tx_wr_one_cycle", tx_wr, 0);
    chk("tx_log_count", tx_log.size(), 3);
    chk("tx_log_0", tx_log[0], 32'd11);
    chk("tx_log_1", tx_log[1], 32'd22);
    chk("tx_log_2", tx_log[2], 32'd33);

    // Status read after 5 drops
    tx_full  = 1'b1;
    rx_empty = 1'b0;
    do_read(SA, -1, d, r, lat, rc);
    chk("stat_data", d, 32'h0005_0001);
    chk("stat_resp", r, 2'b00);
    chk("stat_lat", lat, 1);
    accept();
    chk("stat_valid_drop", rd_valid, 0);
    wr_req = 1'b1; wr_addr = SA; wr_data = '0;
    model_write(SA, tx_full, e_wr, e_resp);
    tick();
    wr_req = 1'b0;
    do_read(SA, -1, d, r, lat, rc);
    chk("stat_cleared_hi", d[31:16], 16'h0000);
    accept();
    tx_full  = 1'b0;
    rx_empty = 1'b1;

    // Non-empty FIFO read with back-pressure
    rx_q.push_back(32'hCAFE_F00D);
    rx_empty = 1'b0;
    p0 = n_pops;
    do_read(FA, -1, d, r, lat, rc);
    chk("fifo_lat", lat, 2 + RL);
    chk("fifo_pop_off", last_pop_cyc - rc, 1);
    chk("fifo_pops", n_pops - p0, 1);
    chk("fifo_data", d, 32'hCAFE_F00D);
    chk("fifo_resp", r, 2'b00);
    rx_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold%0d_valid", i), rd_valid, 1);
      chk($sformatf("hold%0d_data", i), rd_data, 32'hCAFE_F00D);
    end
    accept();
    chk("fifo_valid_drop", rd_valid, 0);

    // Timeout on permanently empty FIFO
    p0 = n_pops;
    do_read(FA, -1, d, r, lat, rc);
    chk("to_lat", lat, TO + 1);
    chk("to_data", d, 32'hDEAD_0000);
    chk("to_resp", r, 2'b10);
    chk("to_no_pop", n_pops - p0, 0);
    accept();

    // FIFO becomes non-empty in poll cycle 5
    rx_q.push_back(32'h1234_5678);
    p0 = n_pops;
    do_read(FA, 5, d, r, lat, rc);
    chk("poll_lat", lat, 8);
    chk("poll_pop_off", last_pop_cyc - rc, 6);
    chk("poll_data", d, 32'h1234_5678);
    chk("poll_resp", r, 2'b00);
    accept();
    rx_empty = 1'b1;

    // Simultaneous DECERR read and write
    wr_req = 1'b1; wr_addr = 32'h600; wr_data = 32'h55;
    rd_req = 1'b1; rd_addr = 32'h600;
    p0 = n_pops;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    chk("dec_wr_ack", wr_ack, 1);
    chk("dec_wr_resp", wr_resp, 2'b11);
    chk("dec_rd_valid", rd_valid, 1);
    chk("dec_rd_resp", rd_resp, 2'b11);
    chk("dec_rd_data", rd_data, 0);
    chk("dec_tx_wr", tx_wr, 0);
    chk("dec_rx_rd", rx_rd, 0);
    accept();

    // Reset while waiting on a popped word
    rx_q.push_back(32'hAAAA_0001);
    rx_q.push_back(32'hAAAA_0002);
    rx_empty = 1'b0;
    rd_req = 1'b1; rd_addr = FA;
    tick();
    rd_req = 1'b0;
    chk("mid_rx_rd", rx_rd, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_rd_resp", rd_resp, 0);
    chk("mid_rst_rx_rd", rx_rd, 0);
    chk("mid_rst_wr_ack", wr_ack, 0);
    chk("mid_rst_tx_din", tx_din, 0);
    tick();
    rst_n = 1'b1;
    exp_drop = '0;
    tick();
    do_read(FA, -1, d, r, lat, rc);
    chk("post_rst_lat", lat, 2 + RL);
    chk("post_rst_data", d, 32'hAAAA_0002);
    accept();
    rx_empty = 1'b1;

    // Random writes against the rule model
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 3);
      wr_req  = ($urandom_range(0, 4) != 0);
      wr_addr = (k < 2) ? FA : (k == 2) ? SA : ($urandom | 32'h1000_0000);
      wr_data = $urandom;
      tx_full = $urandom_range(0, 1) == 1;
      if (wr_req) model_write(wr_addr, tx_full, e_wr, e_resp);
      else begin
        e_wr = 1'b0; e_resp = 2'b00;
      end
      d = wr_data;
      tick();
      chk($sformatf("rw%0d_tx_wr", i), tx_wr, e_wr);
      chk($sformatf("rw%0d_wr_ack", i), wr_ack, wr_req);
      chk($sformatf("rw%0d_wr_resp", i), wr_resp, e_resp);
      if (e_wr) chk($sformatf("rw%0d_tx_din", i), tx_din, d);
    end
    wr_req  = 1'b0;
    tx_full = 1'b0;
    do_read(SA, -1, d, r, lat, rc);
    chk("rw_drop_cnt", d, {exp_drop, 16'h0002});
    accept();

    // Random reads: expected latency computed from the access rules
    for (int i = 0; i < 30; i++) begin
      int kind, rel, e_lat, e_pops;
      logic [31:0] e_data, a;
      logic [1:0]  e_r;
      kind    = $urandom_range(0, 3);
      tx_full = $urandom_range(0, 1) == 1;
      rel     = -1;
      e_pops  = 0;
      a       = FA;
      if (kind == 0) begin
        a        = SA;
        rx_empty = $urandom_range(0, 1) == 1;
        e_data   = {exp_drop, 14'b0, rx_empty, tx_full};
        e_r = 2'b00; e_lat = 1;
      end else if (kind == 1) begin
        a      = $urandom | 32'h2000_0000;
        e_data = '0; e_r = 2'b11; e_lat = 1;
      end else if (kind == 2) begin
        e_data = $urandom;
        rx_q.push_back(e_data);
        rx_empty = 1'b0;
        e_r = 2'b00; e_lat = 2 + RL; e_pops = 1;
      end else begin
        rel = $urandom_range(1, TO + 3);
        if (rel <= TO) begin
          e_data = $urandom;
          rx_q.push_back(e_data);
          e_r = 2'b00; e_lat = rel + 2 + RL; e_pops = 1;
        end else begin
          rel = -1;
          e_data = 32'hDEAD_0000; e_r = 2'b10; e_lat = TO + 1;
        end
      end
      p0 = n_pops;
      do_read(a, rel, d, r, lat, rc);
      chk($sformatf("rr%0d_lat", i), lat, e_lat);
      chk($sformatf("rr%0d_data", i), d, e_data);
      chk($sformatf("rr%0d_resp", i), r, e_r);
      chk($sformatf("rr%0d_pops", i), n_pops - p0, e_pops);
      if (e_pops == 1) chk($sformatf("rr%0d_pop_off", i), last_pop_cyc - rc, e_lat - 1 - RL);
      accept();
      rx_empty = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
